// File: rtl/mux_scan_collector_pkg.sv
// Shared types and constants for the mux scan collector and its settle counter.
package scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  typedef logic [SEL_W-1:0]  ch_t;
  typedef logic [NUM_CH-1:0] word_t;

endpackage

// File: rtl/mux_scan_collector_if.sv
// Select/sample and word handshake bundle between the collector and its neighbours.
// SCAN_PARITY_EN adds word_parity alongside word_out.
interface mux_scan_collector_if;
  import scan_pkg::*;

  logic  start;
  logic  sel0;
  logic  sel1;
  logic  mux_out;
  word_t word_out;
  logic  word_valid;
  logic  word_ready;
  logic  busy;
`ifdef SCAN_PARITY_EN
  logic  word_parity;

  modport master (
    input  start, mux_out, word_ready,
    output sel0, sel1, word_out, word_valid, busy, word_parity
  );
  modport slave (
    output start, mux_out, word_ready,
    input  sel0, sel1, word_out, word_valid, busy, word_parity
  );
`else
  modport master (
    input  start, mux_out, word_ready,
    output sel0, sel1, word_out, word_valid, busy
  );
  modport slave (
    output start, mux_out, word_ready,
    input  sel0, sel1, word_out, word_valid, busy
  );
`endif

endinterface

// File: rtl/mux_scan_collector_settle_counter.sv
// Down-counter timing how long a select is held before its sample is taken.
module settle_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_collector.sv
// Steps a 4:1 mux through channels 0..3, samples each, and offers the 4-bit word on valid/ready.
// Define SCAN_PARITY_EN to add a registered word_parity output.
module mux_scan_collector
  import scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_collector_if.master bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e state_d, state_q;
  ch_t    ch_d, ch_q;
  word_t  shadow_d, shadow_q;
  word_t  word_d, word_q;
  logic   valid_d, valid_q;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  settle_counter #(
    .CNT_W(CNT_W)
  ) u_settle_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(RELOAD),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ch_d     = '0;
          cnt_load = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_SAMPLE: begin
        shadow_d[ch_q] = bus.mux_out;
        if (ch_q != ch_t'(NUM_CH - 1)) begin
          ch_d     = ch_q + 1'b1;
          cnt_load = 1'b1;
          state_d  = S_SETTLE;
        end else begin
          // last bit bypasses the shadow so the word is complete on this same edge
          word_d  = {bus.mux_out, shadow_q[NUM_CH-2:0]};
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.word_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SCAN_PARITY_EN
  logic parity_d, parity_q;

  assign parity_d = ^word_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.word_parity = parity_q;
`endif

  assign bus.sel0       = ch_q[0];
  assign bus.sel1       = ch_q[1];
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_collector.sv
// Scoreboarded random bench for mux_scan_collector with SETTLE_CYCLES=1 and a behavioural 4:1 mux.
module tb_mux_scan_collector;

  logic       clk;
  logic       rst;
  logic [3:0] mux_i;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_words;
  logic [3:0]  exp_q[$];

  mux_scan_collector_if bus();

  assign bus.mux_out = mux_i[{bus.sel1, bus.sel0}];

  mux_scan_collector #(
    .SETTLE_CYCLES(1),
    .CNT_W        (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sel"}, {bus.sel1, bus.sel0}, 0);
    chk({tag, "_word"}, bus.word_out, 0);
    chk({tag, "_valid"}, bus.word_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
`ifdef SCAN_PARITY_EN
    chk({tag, "_parity"}, bus.word_parity, 0);
`endif
  endtask

  // Monitor: every rising word_valid must match the next queued word; the word must not move while valid.
  initial begin
    logic       prev_valid;
    logic [3:0] held;
    logic [3:0] e;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.word_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("word", bus.word_out, e);
`ifdef SCAN_PARITY_EN
            chk("parity", bus.word_parity, ^e);
`endif
            n_words++;
          end
          held = bus.word_out;
        end else if (bus.word_valid) begin
          chk("word_stable", bus.word_out, held);
        end
        prev_valid = bus.word_valid;
      end
    end
  end

  // One scan: channel k is sampled at edge 2k+2 after the start edge, so pat[k] is driven on the
  // preceding negedge and junk on the settle edges in between. Expected bit k is pat[k][k].
  task automatic run_scan(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
                          input logic [3:0] p3, input int rdy_delay, input bit poke,
                          input bit start_at_hs);
    logic [3:0] pat[4];
    logic [3:0] exp;
    int         exp_ch;
    pat = '{p0, p1, p2, p3};
    exp = {p3[3], p2[2], p1[1], p0[0]};
    @(negedge clk);
    bus.start = 1'b1;
    mux_i     = 4'($urandom);
    for (int t = 0; t <= 8; t++) begin
      @(negedge clk);
      bus.start      = poke && (t == 3);
      bus.word_ready = (t < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_ch = (t < 8) ? t / 2 : 3;
      chk("sel", {bus.sel1, bus.sel0}, exp_ch);
      chk("busy", bus.busy, 1);
      chk("valid_timing", bus.word_valid, (t >= 8) ? 1 : 0);
      if (t < 8) mux_i = (t % 2 == 1) ? pat[t / 2] : 4'($urandom);
      if (t == 7) exp_q.push_back(exp);
    end
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      chk("hold_valid", bus.word_valid, 1);
      chk("hold_sel", {bus.sel1, bus.sel0}, 3);
    end
    bus.word_ready = 1'b1;
    bus.start      = start_at_hs;
    @(negedge clk);
    chk("valid_drop", bus.word_valid, 0);
    chk("busy_drop", bus.busy, 0);
    chk("word_retained", bus.word_out, exp);
    bus.word_ready = 1'b0;
    bus.start      = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_sel", {bus.sel1, bus.sel0}, 3);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    n_words        = 0;
    rst            = 1'b1;
    mux_i          = '0;
    bus.start      = 1'b0;
    bus.word_ready = 1'b0;
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_scan(4'b1010, 4'b1010, 4'b1010, 4'b1010, 0, 1'b0, 1'b0);
    run_scan(4'b0110, 4'b0110, 4'b0110, 4'b0110, 5, 1'b0, 1'b0);
    run_scan(4'b0101, 4'b0101, 4'b0101, 4'b0101, 1, 1'b1, 1'b0);
    run_scan(4'b0000, 4'b1000, 4'b1000, 4'b1000, 2, 1'b0, 1'b1);

    // Reset mid-scan: nothing from the aborted scan may appear.
    @(negedge clk);
    bus.start = 1'b1;
    mux_i     = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_reset_valid", bus.word_valid, 0);
      chk("post_reset_busy", bus.busy, 0);
    end
    run_scan(4'b1111, 4'b1111, 4'b1111, 4'b1111, 0, 1'b0, 1'b0);

    run_scan(4'b0111, 4'b0111, 4'b0111, 4'b0111, 0, 1'b0, 1'b0);
    run_scan(4'b0011, 4'b0011, 4'b0011, 4'b0011, 0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_scan(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("words_seen", n_words, 27);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
